// File: rtl/energy_det_pkg.sv
// Shared types and helpers for the energy threshold detector.
// Optional floor tracking is enabled by defining ENERGY_DET_TRACK_EN.
package energy_det_pkg;

   typedef enum logic {CAL = 1'b0, RUN = 1'b1} det_state_e;

   localparam int EW_DEFAULT  = 30;
   localparam int TRACK_SHIFT = 4;

   // The product saturates to 2^w-1. Wide operands keep any EW up to 64 exact.
   function automatic logic [63:0] sat_mul(input logic [63:0] a,
                                           input logic [7:0]  m,
                                           input int unsigned w);
      logic [71:0] p;
      logic [71:0] lim;
      p   = {8'd0, a} * {64'd0, m};
      lim = (72'd1 << w) - 72'd1;
      return (p > lim) ? lim[63:0] : p[63:0];
   endfunction

endpackage

// File: rtl/energy_threshold_detector_pulse_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for strobes from the square adder.
module pulse_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sync3_q, sync3_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
      end
   end

   assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/energy_threshold_detector.sv
// Frame-energy occupancy detector: calibrates a noise floor, then decides with hysteresis.
// Define ENERGY_DET_TRACK_EN to let vacant frames slowly adapt the floor in RUN.
module energy_threshold_detector
   import energy_det_pkg::*;
#(
   parameter int EW       = EW_DEFAULT,
   parameter int CAL_LOG2 = 3,
   parameter int HI_MULT  = 4,
   parameter int LO_MULT  = 2,
   parameter int HOLD     = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [EW-1:0] energy_in,
   input  logic          complete_in,
   input  logic          recal,
   output logic          occupied,
   output logic          decision_valid,
   output logic          cal_done,
   output logic [EW-1:0] noise_floor,
   output logic [EW-1:0] energy_q
);

   localparam int SW  = EW + CAL_LOG2;
   localparam int CW  = CAL_LOG2 + 1;
   localparam int HCW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);

   logic frame_evt;

   det_state_e    state_q, state_d;
   logic          evt_q, evt_d;
   logic [EW-1:0] energy_cap_q, energy_cap_d;
   logic [SW-1:0] sum_q, sum_d;
   logic [CW-1:0] cal_cnt_q, cal_cnt_d;
   logic [HCW-1:0] hi_cnt_q, hi_cnt_d;
   logic [HCW-1:0] lo_cnt_q, lo_cnt_d;
   logic          occupied_q, occupied_d;
   logic          dvalid_q, dvalid_d;
   logic [EW-1:0] floor_q, floor_d;
   logic [EW-1:0] thr_hi_q, thr_hi_d;
   logic [EW-1:0] thr_lo_q, thr_lo_d;

   logic [SW-1:0]  sum_next;
   logic [EW-1:0]  floor_cal;
   logic           cal_last;
   logic [HCW-1:0] hi_inc, lo_inc;

   pulse_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (complete_in),
      .rise     (frame_evt)
   );

   // A frame event coinciding with recal is dropped before capture.
   always_comb begin
      evt_d        = 1'b0;
      energy_cap_d = energy_cap_q;
      if (frame_evt && !recal) begin
         evt_d        = 1'b1;
         energy_cap_d = energy_in[EW-1] ? '0 : energy_in;
      end
   end

   assign sum_next  = sum_q + SW'(energy_cap_q);
   assign cal_last  = (cal_cnt_q == CW'((1 << CAL_LOG2) - 1));
   assign floor_cal = (EW'(sum_next >> CAL_LOG2) == '0) ? EW'(1) : EW'(sum_next >> CAL_LOG2);
   assign hi_inc    = hi_cnt_q + HCW'(1);
   assign lo_inc    = lo_cnt_q + HCW'(1);

`ifdef ENERGY_DET_TRACK_EN
   logic signed [EW:0]   trk_diff;
   logic signed [EW:0]   trk_step;
   logic signed [EW+1:0] trk_sum;
   logic [EW-1:0]        floor_trk;

   always_comb begin
      trk_diff  = $signed({1'b0, energy_cap_q}) - $signed({1'b0, floor_q});
      trk_step  = trk_diff >>> TRACK_SHIFT;
      trk_sum   = $signed({trk_step[EW], trk_step}) + $signed({2'b00, floor_q});
      floor_trk = (trk_sum[EW+1] || trk_sum == '0) ? EW'(1) : trk_sum[EW-1:0];
   end
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (recal)
         state_d = CAL;
      else if (evt_q && state_q == CAL && cal_last)
         state_d = RUN;
   end

   // Datapath: calibration accumulation, hysteresis counters, floor/threshold updates
   always_comb begin
      sum_d      = sum_q;
      cal_cnt_d  = cal_cnt_q;
      hi_cnt_d   = hi_cnt_q;
      lo_cnt_d   = lo_cnt_q;
      occupied_d = occupied_q;
      dvalid_d   = 1'b0;
      floor_d    = floor_q;
      thr_hi_d   = EW'(sat_mul(64'(floor_q), 8'(HI_MULT), EW));
      thr_lo_d   = EW'(sat_mul(64'(floor_q), 8'(LO_MULT), EW));
      if (recal) begin
         sum_d     = '0;
         cal_cnt_d = '0;
         hi_cnt_d  = '0;
         lo_cnt_d  = '0;
      end else if (evt_q) begin
         if (state_q == CAL) begin
            sum_d     = sum_next;
            cal_cnt_d = cal_cnt_q + CW'(1);
            if (cal_last) begin
               floor_d   = floor_cal;
               sum_d     = '0;
               cal_cnt_d = '0;
            end
         end else begin
            dvalid_d = 1'b1;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
            if (!occupied_q && energy_cap_q > thr_hi_q) begin
               hi_cnt_d = hi_inc;
               if (hi_inc >= HCW'(HOLD)) begin
                  occupied_d = 1'b1;
                  hi_cnt_d   = '0;
               end
            end else if (occupied_q && energy_cap_q < thr_lo_q) begin
               lo_cnt_d = lo_inc;
               if (lo_inc >= HCW'(HOLD)) begin
                  occupied_d = 1'b0;
                  lo_cnt_d   = '0;
               end
            end
`ifdef ENERGY_DET_TRACK_EN
            if (!occupied_q && energy_cap_q < thr_lo_q)
               floor_d = floor_trk;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= CAL;
         evt_q        <= 1'b0;
         energy_cap_q <= '0;
         sum_q        <= '0;
         cal_cnt_q    <= '0;
         hi_cnt_q     <= '0;
         lo_cnt_q     <= '0;
         occupied_q   <= 1'b0;
         dvalid_q     <= 1'b0;
         floor_q      <= '0;
         thr_hi_q     <= '0;
         thr_lo_q     <= '0;
      end else begin
         state_q      <= state_d;
         evt_q        <= evt_d;
         energy_cap_q <= energy_cap_d;
         sum_q        <= sum_d;
         cal_cnt_q    <= cal_cnt_d;
         hi_cnt_q     <= hi_cnt_d;
         lo_cnt_q     <= lo_cnt_d;
         occupied_q   <= occupied_d;
         dvalid_q     <= dvalid_d;
         floor_q      <= floor_d;
         thr_hi_q     <= thr_hi_d;
         thr_lo_q     <= thr_lo_d;
      end
   end

   // Output logic
   always_comb begin
      cal_done       = (state_q == RUN);
      occupied       = occupied_q;
      decision_valid = dvalid_q;
      noise_floor    = floor_q;
      energy_q       = energy_cap_q;
   end

endmodule

// File: tb/tb_energy_threshold_detector.sv
// Scoreboarded bench for energy_threshold_detector: calibration, timing, hysteresis, recal, reset.
module tb_energy_threshold_detector;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [29:0] energy_in = '0;
   logic        complete_in = 1'b0;
   logic        recal = 1'b0;
   logic        occupied, decision_valid, cal_done;
   logic [29:0] noise_floor, energy_q;

   int n_cmp = 0;
   int n_err = 0;
   bit exp_q[$];

   typedef struct {
      logic [29:0] e;
      bit          occ;
   } vec_t;
   vec_t vecs[10];

   energy_threshold_detector dut (
      .clk            (clk),
      .reset          (reset),
      .energy_in      (energy_in),
      .complete_in    (complete_in),
      .recal          (recal),
      .occupied       (occupied),
      .decision_valid (decision_valid),
      .cal_done       (cal_done),
      .noise_floor    (noise_floor),
      .energy_q       (energy_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Every decision_valid must match a queued expectation
   always @(negedge clk) begin
      if (!reset && decision_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_decision: got decision_valid=1 expected 0");
         end else begin
            check("decision_occupied", occupied, exp_q.pop_front());
         end
      end
   end

   task automatic frame(input logic [29:0] e, input bit run, input bit exp_occ);
      @(negedge clk);
      energy_in   = e;
      complete_in = 1'b1;
      if (run) exp_q.push_back(exp_occ);
      repeat (4) @(negedge clk);
      complete_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{30'd4001, 1'b0};
      vecs[1] = '{30'd3000, 1'b0};
      vecs[2] = '{30'd4001, 1'b0};
      vecs[3] = '{30'd3000, 1'b0};
      vecs[4] = '{30'd4001, 1'b0};
      vecs[5] = '{30'd4001, 1'b1};
      vecs[6] = '{30'd1999, 1'b1};
      vecs[7] = '{30'd2000, 1'b1};
      vecs[8] = '{30'd1999, 1'b1};
      vecs[9] = '{30'd1999, 1'b0};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_occupied", occupied, 0);
      check("rst_dvalid", decision_valid, 0);
      check("rst_cal_done", cal_done, 0);
      check("rst_floor", noise_floor, 0);
      check("rst_energy_q", energy_q, 0);

      // Calibration at 1000
      for (int i = 0; i < 8; i++) begin
         frame(30'd1000, 1'b0, 1'b0);
         if (i == 6) check("cal_done_after_7", cal_done, 0);
      end
      check("cal_done_after_8", cal_done, 1);
      check("floor_1000", noise_floor, 1000);
      check("occ_after_cal", occupied, 0);

      // Capture and decision timing, with a long-held completion level
      @(negedge clk);
      energy_in   = 30'd2500;
      complete_in = 1'b1;
      exp_q.push_back(1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 check("eq_before_N2", energy_q, 1000);
      @(posedge clk);
      #1 check("eq_at_N2", energy_q, 2500);
      check("dv_low_at_N2", decision_valid, 0);
      @(posedge clk);
      #1 check("dv_high_at_N3", decision_valid, 1);
      @(posedge clk);
      #1 check("dv_low_at_N4", decision_valid, 0);
      repeat (16) @(negedge clk);
      complete_in = 1'b0;
      repeat (4) @(negedge clk);

      // Hysteresis table
      for (int i = 0; i < 10; i++) begin
         frame(vecs[i].e, 1'b1, vecs[i].occ);
         check("table_occupied", occupied, vecs[i].occ);
      end

      // Vacant frame 840: floor adapts only with tracking enabled
      frame(30'd840, 1'b1, 1'b0);
`ifdef ENERGY_DET_TRACK_EN
      check("track_floor", noise_floor, 990);
`else
      check("frozen_floor", noise_floor, 1000);
`endif

      // recal then reset mid-calibration after 5 frames
      @(negedge clk);
      recal = 1'b1;
      @(negedge clk);
      recal = 1'b0;
      check("recal_cal_done", cal_done, 0);
`ifdef ENERGY_DET_TRACK_EN
      check("recal_floor_hold", noise_floor, 990);
`else
      check("recal_floor_hold", noise_floor, 1000);
`endif
      for (int i = 0; i < 5; i++) frame(30'd7000, 1'b0, 1'b0);
      check("midcal_eq", energy_q, 7000);
      do_reset();
      check("midrst_floor", noise_floor, 0);
      check("midrst_eq", energy_q, 0);
      check("midrst_occ", occupied, 0);
      check("midrst_cal_done", cal_done, 0);

      // Calibration of all-zero frames restarts from 0
      for (int i = 0; i < 8; i++) begin
         frame(30'd0, 1'b0, 1'b0);
         if (i == 6) check("zero_cal_after_7", cal_done, 0);
      end
      check("zero_cal_done", cal_done, 1);
      check("zero_floor_one", noise_floor, 1);

      // Negative energy clamps to 0
      frame(30'h3FFFFFFB, 1'b1, 1'b0);
      check("neg_clamp", energy_q, 0);

      frame(30'd100, 1'b1, 1'b0);
      frame(30'd100, 1'b1, 1'b1);
      check("occ_before_recal", occupied, 1);

      // recal coincident with the frame event: frame is dropped
      @(negedge clk);
      energy_in   = 30'd9999;
      complete_in = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      recal = 1'b1;
      @(negedge clk);
      recal = 1'b0;
      repeat (2) @(negedge clk);
      complete_in = 1'b0;
      repeat (4) @(negedge clk);
      check("drop_eq", energy_q, 100);
      check("drop_cal_done", cal_done, 0);

      for (int i = 0; i < 8; i++) begin
         frame(30'd500, 1'b0, 1'b0);
         if (i == 3) check("occ_hold_mid_cal", occupied, 1);
         if (i == 6) check("recal_cal_after_7", cal_done, 0);
      end
      check("recal_floor_500", noise_floor, 500);
      check("recal_cal_done", cal_done, 1);
      check("recal_occ_hold", occupied, 1);

      repeat (4) @(negedge clk);
      check("pending_decisions", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
